// File: rtl/fwd_select_ctrl_pkg.sv
// Shared definitions for the EX operand forwarding controller.
// Optional macro FWD_STATS_EN (used in fwd_select_ctrl.sv) adds statistics counters.
package fwd_select_ctrl_pkg;

   // Width of the destination index held in each shadow stage.
   localparam int SHADOW_AW = 5;

   // Operand mux selects as seen by the 3:1 forwarding muxes in EX.
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   // Control bits tracked for an instruction as it moves down the pipe.
   typedef struct packed {
      logic                 valid;
      logic [SHADOW_AW-1:0] rd;
      logic                 regwrite;
      logic                 memread;
   } stage_shadow_t;

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-operand forwarding decision: compares one source index against the
// instructions currently in EX and MEM and picks the youngest producer.
module fwd_src_cmp
   import fwd_select_ctrl_pkg::*;
#(
   parameter int REG_AW = SHADOW_AW
) (
   input  logic [REG_AW-1:0] src,
   input  stage_shadow_t     ex_shadow,
   input  stage_shadow_t     mem_shadow,
   output logic [1:0]        sel
);

   logic ex_hit;
   logic mem_hit;
   logic unused_memread;

   // Load flags matter only to the stall logic in the parent.
   assign unused_memread = ex_shadow.memread ^ mem_shadow.memread;

   // r0 is hardwired to zero, so a write to it is never a real producer.
   always_comb begin
      ex_hit  = (src != '0) && ex_shadow.valid && ex_shadow.regwrite
                && (ex_shadow.rd == src);
      mem_hit = (src != '0) && mem_shadow.valid && mem_shadow.regwrite
                && (mem_shadow.rd == src);
   end

   // EX producer wins over MEM producer: it holds the newer value.
   always_comb begin
      sel = FWD_RF;
      if (ex_hit) begin
         sel = FWD_EXMEM;
      end else if (mem_hit) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fwd_select_ctrl.sv
// Forwarding select and load-use stall controller for the EX operand muxes.
// Selects are registered so they line up with the instruction once it is in EX.
// Define FWD_STATS_EN to add saturating fwd_cnt / stall_cnt statistics outputs.
module fwd_select_ctrl
   import fwd_select_ctrl_pkg::*;
#(
   parameter int REG_AW = SHADOW_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              flush,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall
`ifdef FWD_STATS_EN
   ,
   output logic [CNT_W-1:0]  fwd_cnt,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   stage_shadow_t     ex_reg, mem_reg, wb_reg;
   stage_shadow_t     ex_next;
   logic              entry_bubble;
   logic [REG_AW-1:0] src_idx  [2];
   logic [1:0]        cmp_sel  [2];
   logic [1:0]        sel_next [2];
   logic [1:0]        sel_reg  [2];
   logic              unused_wb;

   // The WB shadow is kept for visibility; the register file handles WB itself.
   assign unused_wb = ^wb_reg;

   assign src_idx[0] = id_rs;
   assign src_idx[1] = id_rt;

   // One comparator per EX operand; each also produces the registered select.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp (
            .src        (src_idx[gi]),
            .ex_shadow  (ex_reg),
            .mem_shadow (mem_reg),
            .sel        (cmp_sel[gi])
         );

         // A bubble entering EX never drives a forwarding select.
         always_comb begin
            sel_next[gi] = entry_bubble ? FWD_RF : cmp_sel[gi];
         end

         // Select register aligned with the EX shadow stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sel_reg[gi] <= FWD_RF;
            end else begin
               sel_reg[gi] <= sel_next[gi];
            end
         end
      end
   endgenerate

   assign fwd_a_sel = sel_reg[0];
   assign fwd_b_sel = sel_reg[1];

   // Load in EX feeding the instruction in ID: its data is only ready after MEM.
   always_comb begin
      stall = id_valid && ex_reg.valid && ex_reg.memread && (ex_reg.rd != '0)
              && ((ex_reg.rd == id_rs) || (ex_reg.rd == id_rt));
   end

   // EX entry: flush takes priority, but either flush or stall yields a bubble.
   always_comb begin
      entry_bubble = flush || stall || !id_valid;
      ex_next      = stage_shadow_t'('0);
      if (!entry_bubble) begin
         ex_next.valid    = 1'b1;
         ex_next.rd       = id_rd;
         ex_next.regwrite = id_regwrite;
         ex_next.memread  = id_memread;
      end
   end

   // Shadow pipeline: MEM and WB always advance, even while ID is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_reg  <= stage_shadow_t'('0);
         mem_reg <= stage_shadow_t'('0);
         wb_reg  <= stage_shadow_t'('0);
      end else begin
         ex_reg  <= ex_next;
         mem_reg <= ex_reg;
         wb_reg  <= mem_reg;
      end
   end

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] fwd_cnt_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   // Saturating counters of forwarding events and stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_cnt_reg   <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (((sel_next[0] != FWD_RF) || (sel_next[1] != FWD_RF))
             && (fwd_cnt_reg != '1)) begin
            fwd_cnt_reg <= fwd_cnt_reg + CNT_W'(1);
         end
         if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign fwd_cnt   = fwd_cnt_reg;
   assign stall_cnt = stall_cnt_reg;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed bench for fwd_select_ctrl: hand-computed stall and select values.
module tb_fwd_select_ctrl;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       id_regwrite;
   logic       id_memread;
   logic       flush;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       stall;
`ifdef FWD_STATS_EN
   logic [15:0] fwd_cnt;
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fwd_select_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
      .fwd_a_sel   (fwd_a_sel),
      .fwd_b_sel   (fwd_b_sel),
      .stall       (stall)
`ifdef FWD_STATS_EN
      ,
      .fwd_cnt     (fwd_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one ID-stage cycle, check stall before the edge and the
   // registered selects just after it.
   task automatic issue(input string tag, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic fl, input logic exp_stall,
                        input logic [1:0] exp_a, input logic [1:0] exp_b);
      @(negedge clk);
      id_valid    = v;
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
      id_regwrite = rw;
      id_memread  = mr;
      flush       = fl;
      #1;
      check({tag, ".stall"}, {3'b0, stall}, {3'b0, exp_stall});
      @(posedge clk);
      #1;
      check({tag, ".a"}, {2'b0, fwd_a_sel}, {2'b0, exp_a});
      check({tag, ".b"}, {2'b0, fwd_b_sel}, {2'b0, exp_b});
      $display("txn %s v=%0b rs=%0d rt=%0d rd=%0d rw=%0b mr=%0b fl=%0b -> stall=%0b a=%0b b=%0b",
               tag, v, rs, rt, rd, rw, mr, fl, exp_stall, fwd_a_sel, fwd_b_sel);
   endtask

   task automatic nop(input string tag);
      issue(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
   endtask

   initial begin
      rst_n       = 1'b0;
      id_valid    = 1'b0;
      id_rs       = '0;
      id_rt       = '0;
      id_rd       = '0;
      id_regwrite = 1'b0;
      id_memread  = 1'b0;
      flush       = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset.a", {2'b0, fwd_a_sel}, 4'h0);
      check("reset.b", {2'b0, fwd_b_sel}, 4'h0);
      check("reset.stall", {3'b0, stall}, 4'h0);
      rst_n = 1'b1;

      // Distance-1 producer on operand A.
      issue("t2.prod", 1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t2.cons", 1, 5'd3, 5'd4, 5'd10, 1, 0, 0, 0, 2'b01, 2'b00);
      nop("t2.n0"); nop("t2.n1");

      // Distance-2 producer on operand B.
      issue("t3.prod", 1, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t3.ind",  1, 5'd1, 5'd2, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t3.cons", 1, 5'd1, 5'd5, 5'd11, 1, 0, 0, 0, 2'b00, 2'b10);
      nop("t3.n0"); nop("t3.n1");

      // Two producers of r7: the younger one wins.
      issue("t4.p2", 1, 5'd1, 5'd2, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t4.p1", 1, 5'd1, 5'd2, 5'd7, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t4.cons", 1, 5'd7, 5'd7, 5'd12, 1, 0, 0, 0, 2'b01, 2'b01);
      nop("t4.n0"); nop("t4.n1");

      // Load-use: one stall cycle, bubble, then MEM/WB forward.
      issue("t5.lw",    1, 5'd1, 5'd2, 5'd8, 1, 1, 0, 0, 2'b00, 2'b00);
      issue("t5.stall", 1, 5'd8, 5'd3, 5'd13, 1, 0, 0, 1, 2'b00, 2'b00);
      issue("t5.cons",  1, 5'd8, 5'd3, 5'd13, 1, 0, 0, 0, 2'b10, 2'b00);
      nop("t5.n0"); nop("t5.n1");

      // r0 writers never forward and never stall.
      issue("t6.w0",   1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t6.r0a",  1, 5'd0, 5'd0, 5'd14, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t6.r0b",  1, 5'd0, 5'd1, 5'd15, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t6.lw0",  1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00);
      issue("t6.r0c",  1, 5'd0, 5'd0, 5'd16, 1, 0, 0, 0, 2'b00, 2'b00);
      nop("t6.n0"); nop("t6.n1");

      // Flush during a load-use stall: bubble, no second stall cycle.
      issue("t6.lw9",  1, 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 2'b00, 2'b00);
      issue("t6.flst", 1, 5'd9, 5'd1, 5'd18, 1, 0, 1, 1, 2'b00, 2'b00);
      issue("t6.redir",1, 5'd9, 5'd9, 5'd16, 1, 0, 0, 0, 2'b10, 2'b10);
      // A flushed producer must not be forwarded.
      issue("t6.fl17", 1, 5'd1, 5'd2, 5'd17, 1, 0, 1, 0, 2'b00, 2'b00);
      issue("t6.r17",  1, 5'd17, 5'd2, 5'd19, 1, 0, 0, 0, 2'b00, 2'b00);
      nop("t6.n2"); nop("t6.n3");

      // Reset mid-stream with shadows full and a pending load-use stall.
      issue("t1.p20", 1, 5'd1, 5'd2, 5'd20, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t1.p21", 1, 5'd20, 5'd1, 5'd21, 1, 0, 0, 0, 2'b01, 2'b00);
      issue("t1.lw22", 1, 5'd21, 5'd20, 5'd22, 1, 1, 0, 0, 2'b01, 2'b10);
      @(negedge clk);
      id_valid    = 1'b1;
      id_rs       = 5'd22;
      id_rt       = 5'd22;
      id_rd       = 5'd23;
      id_regwrite = 1'b1;
      id_memread  = 1'b0;
      flush       = 1'b0;
      #1;
      check("t1.pre.stall", {3'b0, stall}, 4'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t1.rst.a", {2'b0, fwd_a_sel}, 4'h0);
      check("t1.rst.b", {2'b0, fwd_b_sel}, 4'h0);
      check("t1.rst.stall", {3'b0, stall}, 4'h0);
      $display("txn t1.rst a=%0b b=%0b stall=%0b", fwd_a_sel, fwd_b_sel, stall);
      id_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      issue("t1.first", 1, 5'd22, 5'd21, 5'd23, 1, 0, 0, 0, 2'b00, 2'b00);
      issue("t1.next",  1, 5'd23, 5'd1, 5'd24, 1, 0, 0, 0, 2'b01, 2'b00);
      nop("t1.n0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
